// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port ram between two bus masters.
//   Port 0 is the ktc16 core. Port 1 is a loader, debug or DMA master.
//   Arbitration is round-robin. An owner may hold a bounded locked burst
//   of up to MAX_BURST back-to-back transfers.
//
// Optional feature: define MEM_ARB_STATS_EN to build the transfer and
// contention counters. When it is undefined, the stat ports are tied to
// zero and no counter flops are built.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   reqN, weN, lockN           master N request, write enable, burst lock
//   addrN, wdN                 master N address and write data
//   gntN                       registered grant to master N
//   rdataN                     mem_rd while gntN is high, otherwise 0
//   mem_we, mem_addr, mem_wd   ram write enable, address and write data
//   mem_rd                     ram combinational read data
//   stat_gnt0, stat_gnt1       transfers completed per master
//   stat_wait                  cycles in which some master waited
//
// State table:
//   OWN_NONE | bus idle; no master granted
//   OWN_M0   | master 0 granted
//   OWN_M1   | master 1 granted

module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_wait
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    owner_t        owner_q, owner_d;
    logic          last_q, last_d;     // 1 = master 1 made the latest transfer
    logic [BW-1:0] burst_q, burst_d;

    logic xfer0, xfer1;
    logic elig0, elig1;
    logic stay_locked;

    assign gnt0  = (owner_q == OWN_M0);
    assign gnt1  = (owner_q == OWN_M1);
    assign xfer0 = gnt0 & req0;
    assign xfer1 = gnt1 & req1;

    // A master that transferred this edge has had its request consumed.
    assign elig0 = req0 & ~xfer0;
    assign elig1 = req1 & ~xfer1;

    assign stay_locked = ((xfer0 & lock0) | (xfer1 & lock1)) && (burst_q < BURST_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;           // master 0 wins the first tie
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;

        if (xfer0) begin
            last_d = 1'b0;
        end else if (xfer1) begin
            last_d = 1'b1;
        end

        if (stay_locked) begin
            burst_d = burst_q + 1'b1;
        end else begin
            burst_d = '0;
            if (elig0 && elig1) begin
                owner_d = last_q ? OWN_M0 : OWN_M1;
            end else if (elig0) begin
                owner_d = OWN_M0;
            end else if (elig1) begin
                owner_d = OWN_M1;
            end else begin
                owner_d = OWN_NONE;
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        case (owner_q)
            OWN_M0: begin
                mem_we   = req0 & we0;
                mem_addr = addr0;
                mem_wd   = wd0;
            end
            OWN_M1: begin
                mem_we   = req1 & we1;
                mem_addr = addr1;
                mem_wd   = wd1;
            end
            default: begin
                mem_we   = 1'b0;
                mem_addr = '0;
                mem_wd   = '0;
            end
        endcase
    end

    assign rdata0 = gnt0 ? mem_rd : '0;
    assign rdata1 = gnt1 ? mem_rd : '0;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_gnt0_q, stat_gnt1_q, stat_wait_q;
    logic        wait_any;

    assign wait_any = (req0 & ~gnt0) | (req1 & ~gnt1);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_gnt0_q <= '0;
            stat_gnt1_q <= '0;
            stat_wait_q <= '0;
        end else begin
            if (xfer0) begin
                stat_gnt0_q <= stat_gnt0_q + 32'd1;
            end
            if (xfer1) begin
                stat_gnt1_q <= stat_gnt1_q + 32'd1;
            end
            if (wait_any) begin
                stat_wait_q <= stat_wait_q + 32'd1;
            end
        end
    end

    assign stat_gnt0 = stat_gnt0_q;
    assign stat_gnt1 = stat_gnt1_q;
    assign stat_wait = stat_wait_q;
`else
    assign stat_gnt0 = '0;
    assign stat_gnt1 = '0;
    assign stat_wait = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `ram` instance between the `ktc16` core (port 0) and a second bus master (port 1, loader/debug/DMA). It sits between the masters and `ram`. It owns `memwrite`, `addr` and `wd` into `ram`, and returns `rd` to whichever master holds the grant. Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.

## Interface
Parameters:
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `MAX_BURST`, 4: maximum consecutive transfers one locked owner may make (≥1)

Ports (`i` ∈ {0,1}):
- `clk`  in  1: clock, all state updates on rising edge
- `reset`  in  1: synchronous, active-high
- `req_i`  in  1: master i requests a transfer; held with `we_i`/`addr_i`/`wd_i` stable until completion
- `we_i`  in  1: 1 = write, 0 = read
- `lock_i`  in  1: master i requests to keep the grant after this transfer
- `addr_i`  in  ADDR_W: address
- `wd_i`  in  DATA_W: write data
- `gnt_i`  out  1: registered grant to master i
- `rdata_i`  out  DATA_W: `rd` when `gnt_i`=1, else 0
- `mem_we`  out  1: to `ram` `memwrite`
- `mem_addr`  out  ADDR_W: to `ram` `addr`
- `mem_wd`  out  DATA_W: to `ram` `wd`
- `mem_rd`  in  DATA_W: from `ram` `rd`, combinational read
- `stat_gnt0`, `stat_gnt1`  out  32: transfer counters (see Configuration)
- `stat_wait`  out  32: contention counter (see Configuration)

## Operation
- State register `owner` ∈ {NONE, M0, M1}.
- `gnt0 = (owner==M0)`, `gnt1 = (owner==M1)`. At most one grant is high.
- Transfer: a cycle with `gnt_i && req_i`. It completes at the next rising edge.
- Memory-side outputs:
  - `mem_addr`/`mem_wd` mux from the owner (0 when NONE).
  - `mem_we = gnt_i && req_i && we_i`. A granted master with `req_i`=0 causes no write.
- Read data: `rdata_i` is valid combinationally during the transfer cycle. The master captures it at the completing edge.
- `last` register holds the most recent transferring master and is updated on every transfer.
- `burst_cnt` (log2(MAX_BURST) bits) counts consecutive locked transfers by the current owner.
- Next-state rules, evaluated at each rising edge, first match wins:
  1. `reset` → owner=NONE, last=M1 (so M0 wins first tie), burst_cnt=0.
  2. Owner i transfers with `lock_i`=1 and `burst_cnt < MAX_BURST-1` → stay i, burst_cnt+1.
  3. Otherwise the eligible set is every master with `req`=1, excluding the owner if it transferred this edge (its request is consumed).
     - Both eligible → the one ≠ `last`.
     - One eligible → that one.
     - None → NONE.
     - burst_cnt=0 on any decision under rule 3.
- Unlocked single master: one transfer per 2 cycles (grant, re-request). Locked: back-to-back transfers up to MAX_BURST.
- Starvation bound: a requesting master is granted within MAX_BURST+1 cycles of raising `req`.
- Owner drops `req` while granted → no transfer, re-arbitrate at next edge (owner is ineligible since its `req`=0).

## Timing
- Reset values: `gnt0`=`gnt1`=0, `mem_we`=0, `mem_addr`=`mem_wd`=0, `rdata_*`=0, stats=0.
  - These hold from the first rising edge with `reset` high, including mid-transfer.
  - A write in flight at that edge is aborted; `mem_we` is 0 in the following cycle.
- Request-to-grant latency: 1 cycle when the bus is free (`req` sampled at edge n, `gnt` high in cycle n+1).
- Write commits at the edge ending the grant cycle (ram write edge).
- No combinational path from `req_*` to `gnt_*`. Combinational paths exist from `req_i`/`we_i` to `mem_we` and from `mem_rd` to `rdata_i`.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - `stat_gnt_i` increments on each transfer by master i.
  - `stat_wait` increments each cycle a master has `req`=1 and `gnt`=0.
  - All wrap at 2^32 and clear on reset.
- Undefined: the ports remain and are tied to 0, with no counter flops.

## Test plan
- Reset, then `req0`=1, `we0`=1, `addr0`=80, `wd0`=144 → `gnt0` high the next cycle, `mem_we`=1, ram[80]=144 after that edge, `gnt0` low one cycle later.
- `req0` and `req1` rise together (reads of 0x10, 0x20), unlocked and held → grants alternate M0, M1, M0, … with 1-cycle grants and `rdata_i` = ram contents.
- MAX_BURST=4, `lock0`=1 and `req0` held, `req1`=1 → exactly 4 consecutive `gnt0` cycles, then `gnt1` (starvation bound met).
- Owner drops `req0` during its grant while `req1`=1 → `mem_we`=0 that cycle, `gnt1` next cycle.
- `reset` asserted during an M1 write → `gnt1`=0 and `mem_we`=0 after that edge, owner NONE; first grant after reset release goes to M0 on a tie.
- With `MEM_ARB_STATS_EN`: 3 M0 transfers, 2 M1 transfers, 5 wait cycles → `stat_gnt0`=3, `stat_gnt1`=2, `stat_wait`=5. Without the macro, all stats read 0.
